// File: rtl/bitmap_gen_param.sv
// bitmap_gen_param: scaled on-chip bitmap display with bouncing-dot writer and clear sequencer
// Ports:
//   clk, rst_n        pixel clock, asynchronous active-low reset
//   btn               raw push button, each press toggles the dot writer
//   sw[1:0]           dot palette select; sw[2] requests a bitmap clear at the next frame tick
//   pixel_x, pixel_y  current raster position from vga_sync
//   video_on          active-video flag from vga_sync
//   rgb               registered pixel colour, two cycles behind pixel_x/pixel_y/video_on
//   busy              high while the clear sequencer runs
module bitmap_gen_param #(
    parameter int BM_W     = 64,
    parameter int BM_H     = 64,
    parameter int COLOR_W  = 8,
    parameter int SCALE_SH = 2,
    parameter int X0       = 100,
    parameter int Y0       = 50,
    parameter int V_ACTIVE = 600,
    parameter logic [COLOR_W-1:0] BG_COLOR = 8'h03,
    parameter logic [COLOR_W-1:0] PAL0     = 8'hE0,
    parameter logic [COLOR_W-1:0] PAL1     = 8'h1C,
    parameter logic [COLOR_W-1:0] PAL2     = 8'h03,
    parameter logic [COLOR_W-1:0] PAL3     = 8'hFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               btn,
    input  logic [2:0]         sw,
    input  logic [10:0]        pixel_x,
    input  logic [10:0]        pixel_y,
    input  logic               video_on,
    output logic [COLOR_W-1:0] rgb,
    output logic               busy
);
    localparam int XW = $clog2(BM_W);
    localparam int YW = $clog2(BM_H);
    localparam int AW = XW + YW;
    localparam int N  = BM_W * BM_H;
    localparam logic [10:0] X_LO   = 11'(X0);
    localparam logic [10:0] X_HI   = 11'(X0 + (BM_W << SCALE_SH));
    localparam logic [10:0] Y_LO   = 11'(Y0);
    localparam logic [10:0] Y_HI   = 11'(Y0 + (BM_H << SCALE_SH));
    localparam logic [10:0] V_TICK = 11'(V_ACTIVE);

    typedef enum logic [1:0] {IDLE, DOT, CLEAR} state_t;

    logic [COLOR_W-1:0] mem [N] = '{default: '0};

    state_t             state, state_n;
    logic               in_win, win_q, von_q;
    logic [XW-1:0]      col, dx, nx;
    logic [YW-1:0]      row, dy, ny;
    logic [AW-1:0]      addr_q, clr_addr, wa;
    logic [COLOR_W-1:0] wd, pal;
    logic               we, b1, b2, b3, btn_rise, run, frame_tick;
    logic               vx_neg, vy_neg, x_hit, y_hit, clr_done;

    // Display read path: window test and cell address, then RAM read straight into rgb.
    assign in_win = pixel_x >= X_LO && pixel_x < X_HI && pixel_y >= Y_LO && pixel_y < Y_HI;
    assign col    = XW'((pixel_x - X_LO) >> SCALE_SH);
    assign row    = YW'((pixel_y - Y_LO) >> SCALE_SH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q  <= 1'b0;
            von_q  <= 1'b0;
            addr_q <= '0;
            rgb    <= '0;
        end else begin
            win_q  <= in_win;
            von_q  <= video_on;
            addr_q <= {row, col};
            rgb    <= !von_q ? '0 : win_q ? mem[addr_q] : BG_COLOR;
        end
    end

    // Write port; non-blocking write keeps read-during-write returning old data.
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    assign btn_rise   = b2 & ~b3;
    assign frame_tick = pixel_x == '0 && pixel_y == V_TICK;
    assign busy       = state == CLEAR;
    assign clr_done   = state == CLEAR && &clr_addr;

    // A hit means the next step would leave the bitmap, so direction flips and
    // the dot steps back inward on the same write.
    assign x_hit = vx_neg ? ~|dx : &dx;
    assign y_hit = vy_neg ? ~|dy : &dy;
    assign nx    = (vx_neg ^ x_hit) ? dx - XW'(1) : dx + XW'(1);
    assign ny    = (vy_neg ^ y_hit) ? dy - YW'(1) : dy + YW'(1);

    always_comb begin
        pal = sw[1] ? (sw[0] ? PAL3 : PAL2) : (sw[0] ? PAL1 : PAL0);
    end

    always_comb begin
        state_n = state;
        we      = 1'b0;
        wa      = {dy, dx};
        wd      = pal;
        unique case (state)
            IDLE:    if (frame_tick) state_n = sw[2] ? CLEAR : run ? DOT : IDLE;
            DOT: begin
                we      = 1'b1;
                state_n = IDLE;
            end
            CLEAR: begin
                we      = 1'b1;
                wa      = clr_addr;
                wd      = '0;
                state_n = clr_done ? IDLE : CLEAR;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            b1       <= 1'b0;
            b2       <= 1'b0;
            b3       <= 1'b0;
            run      <= 1'b0;
            clr_addr <= '0;
            dx       <= '0;
            dy       <= '0;
            vx_neg   <= 1'b0;
            vy_neg   <= 1'b0;
        end else begin
            state <= state_n;
            b1    <= btn;
            b2    <= b1;
            b3    <= b2;
            run   <= run ^ btn_rise;
            if (state == IDLE && frame_tick && sw[2])
                clr_addr <= '0;
            else if (state == CLEAR)
                clr_addr <= clr_addr + AW'(1);
            if (state == DOT) begin
                dx     <= nx;
                dy     <= ny;
                vx_neg <= vx_neg ^ x_hit;
                vy_neg <= vy_neg ^ y_hit;
            end else if (clr_done) begin
                dx     <= '0;
                dy     <= '0;
                vx_neg <= 1'b0;
                vy_neg <= 1'b0;
            end
        end
    end
endmodule
